updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Registered, parametrised modulo-N up/down counter with a built-in step prescaler, synchronous load and wrap/step strobes for cascading. It is the next-generation counter core for the LED counter design. It replaces the fixed mod-6 next-state function with a self-contained sequential block that holds its own state. It can be chained digit-to-digit by feeding one instance's `wrap` into the next instance's `en`.

## Interface
- `WIDTH`, 3: width of count, load_val.
- `MODULUS`, 6: count range 0..MODULUS-1; legal 2 ≤ MODULUS ≤ 2**WIDTH.
- `TICK_DIV`, 4: enabled clock cycles per count step; legal ≥ 1. The internal prescaler width is $clog2(TICK_DIV), minimum 1 bit.

- `clk` input 1: single clock, all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en` input 1: prescaler advance enable; when low, all state holds.
- `up_down` input 1: 1 = count up, 0 = count down; sampled on the step edge.
- `load` input 1: synchronous load request.
- `load_val` input WIDTH: value to load.
- `count` output WIDTH: registered counter value.
- `step` output 1: registered one-cycle strobe, high in the cycle after a step edge.
- `wrap` output 1: registered one-cycle strobe, high in the cycle after a wrapping step.

## Operation
- **Reset.** On an edge with rst_n=0:
  - count=0, prescaler=0, step=0, wrap=0.
  - Reset overrides load and en.
  - Reset asserted mid-prescale discards the partial prescale.
- **Priority** (highest first): reset, load, enabled step, hold.
- **Load.** On an edge with load=1:
  - count ← load_val, or ← MODULUS-1 if load_val ≥ MODULUS (clamp).
  - prescaler ← 0; step ← 0; wrap ← 0.
  - Load works regardless of en.
- **Prescaler.** On an edge with en=1 and load=0:
  - If prescaler == TICK_DIV-1, prescaler ← 0 and a step occurs.
  - Otherwise prescaler ← prescaler+1.
  - With TICK_DIV=1, every enabled edge is a step.
- **Step, up** (up_down=1):
  - count == MODULUS-1 → count ← 0, wrap ← 1.
  - Otherwise count ← count+1.
- **Step, down** (up_down=0):
  - count == 0 → count ← MODULUS-1, wrap ← 1.
  - Otherwise count ← count-1.
- **Strobes.**
  - step ← 1 on every step edge, 0 on every other edge.
  - wrap ← 0 on every non-wrapping edge.
- **Hold.** en=0 and load=0: count and prescaler hold; step and wrap ← 0.
- **Direction change** mid-prescale does not reset the prescaler; the direction sampled at the step edge applies.
- **Arithmetic.** Modular only; count never leaves 0..MODULUS-1 after reset. Increment and decrement are computed at WIDTH bits with explicit compare, never relying on natural 2**WIDTH overflow.
- **Elaboration errors.** Illegal parameters (MODULUS < 2, MODULUS > 2**WIDTH, TICK_DIV < 1) must stop elaboration via a generate-time check.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Step latency: with en held high from prescaler=0, the first step lands on the TICK_DIV-th rising edge. The new count, step=1 and (if wrapping) wrap=1 are all visible in the following cycle.
- Steady state: one step per TICK_DIV enabled cycles. en low cycles stretch the period cycle-for-cycle.
- Load latency: 1 cycle; count shows the loaded value after the load edge.
- step and wrap are exactly one cycle wide. They are never high for two consecutive cycles unless TICK_DIV=1 with continuous en.
- Cascading: wrap of instance k feeds en of instance k+1 (with TICK_DIV=1 there). The next digit then updates one cycle after the lower digit wraps.

## Test plan
- **Reset.** Hold rst_n=0 for 3 edges with en=1 and load=1 → count=0, step=0, wrap=0. Then release with en=1, up_down=1 → first step after 4 edges, count=1.
- **Up wrap** (defaults). Run 24 enabled cycles from 0 → count sequence 1,2,3,4,5,0, with step pulses every 4 cycles. A single wrap pulse coincides with count=0.
- **Down wrap.** Load 0, then up_down=0 for 4 enabled cycles → count=5, wrap=1 for one cycle. The next step gives count=4 with wrap=0.
- **Load edge cases.**
  - load_val=7 → count=5 (clamp).
  - Load asserted on the same edge as a pending step → count=load_val, step=0, prescaler restarts (next step 4 enabled cycles later).
- **en gaps / direction.** en toggled 1,0,1,0,… → step period doubles to 8 cycles. Flip up_down at prescaler=2 → the following step uses the new direction.
- **Cascade.** Two instances, lower TICK_DIV=1 and upper wrap-driven → 36 enabled cycles take the pair from 00 to 00 with exactly one upper-digit wrap. An alternate build with MODULUS=10, WIDTH=4 counts 0..9 correctly.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: modulo-MODULUS up/down counter with a TICK_DIV step
// prescaler, synchronous clamped load, and registered step/wrap strobes that
// can drive the en of the next digit when counters are chained.
module updown_mod_counter #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULUS  = 6,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             wrap
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  // Refuse to elaborate with a modulus or divider the counter cannot honour
  if ((MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH)) || (TICK_DIV < 1)) begin : g_param_check
    $fatal(1, "updown_mod_counter: illegal MODULUS/WIDTH/TICK_DIV combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic             step_q,  step_d;
  logic             wrap_q,  wrap_d;

  // Next-state: load beats an enabled prescaler advance; strobes default low
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      // Out-of-range load values clamp to the top of the count range
      if (32'(load_val) >= 32'(MODULUS)) begin
        count_d = CNT_MAX;
      end else begin
        count_d = load_val;
      end
      pre_d = '0;
    end else if (en) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        step_d = 1'b1;
        if (up_down) begin
          if (count_q == CNT_MAX) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_d = CNT_MAX;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      pre_q   <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: default instance, a two-digit
// cascade, and a decade (MODULUS=10) build.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up_down, load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       step, wrap;

  logic       c_en;
  logic [2:0] lo_count, hi_count;
  logic       lo_step, lo_wrap, hi_step, hi_wrap;

  logic       m_en, m_load;
  logic [3:0] m_load_val, m_count;
  logic       m_step, m_wrap;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  updown_mod_counter dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count(count), .step(step), .wrap(wrap)
  );

  updown_mod_counter #(.WIDTH(3), .MODULUS(6), .TICK_DIV(1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(c_en), .up_down(1'b1), .load(1'b0),
    .load_val(3'd0), .count(lo_count), .step(lo_step), .wrap(lo_wrap)
  );

  updown_mod_counter #(.WIDTH(3), .MODULUS(6), .TICK_DIV(1)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(lo_wrap), .up_down(1'b1), .load(1'b0),
    .load_val(3'd0), .count(hi_count), .step(hi_step), .wrap(hi_wrap)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .TICK_DIV(1)) u_dec (
    .clk(clk), .rst_n(rst_n), .en(m_en), .up_down(1'b1), .load(m_load),
    .load_val(m_load_val), .count(m_count), .step(m_step), .wrap(m_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; load = 1'b1; load_val = 3'd3; up_down = 1'b1;
    repeat (3) tick();
    n_total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (step !== 1'b0) $display("FAIL reset_step: got %b expected 0", step); else n_pass++;
    n_total++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b expected 0", wrap); else n_pass++;
    n_total++; if (lo_count !== 3'd0 || hi_count !== 3'd0) $display("FAIL reset_cascade: got %0d%0d expected 00", hi_count, lo_count); else n_pass++;
    rst_n = 1'b1; load = 1'b0;
    repeat (3) tick();
    n_total++; if (count !== 3'd0 || step !== 1'b0) $display("FAIL release_pre_step: got count=%0d step=%b expected 0/0", count, step); else n_pass++;
    tick();
    n_total++; if (count !== 3'd1) $display("FAIL release_first_step_count: got %0d expected 1", count); else n_pass++;
    n_total++; if (step !== 1'b1) $display("FAIL release_first_step_strobe: got %b expected 1", step); else n_pass++;
  endtask

  task automatic test_up_wrap();
    logic [2:0] exp_c;
    logic       exp_s, exp_w;
    int         wraps;
    load = 1'b1; load_val = 3'd0; en = 1'b0; tick();
    load = 1'b0; en = 1'b1; up_down = 1'b1; wraps = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      exp_c = 3'((i / 4) % 6);
      exp_s = (i % 4 == 0);
      exp_w = (i == 24);
      if (wrap === 1'b1) wraps++;
      n_total++; if (count !== exp_c) $display("FAIL up_count[%0d]: got %0d expected %0d", i, count, exp_c); else n_pass++;
      n_total++; if (step !== exp_s) $display("FAIL up_step[%0d]: got %b expected %b", i, step, exp_s); else n_pass++;
      n_total++; if (wrap !== exp_w) $display("FAIL up_wrap[%0d]: got %b expected %b", i, wrap, exp_w); else n_pass++;
    end
    n_total++; if (wraps != 1) $display("FAIL up_wrap_pulses: got %0d expected 1", wraps); else n_pass++;
  endtask

  task automatic test_down_wrap();
    load = 1'b1; load_val = 3'd0; tick();
    load = 1'b0; en = 1'b1; up_down = 1'b0;
    repeat (3) tick();
    n_total++; if (count !== 3'd0 || step !== 1'b0) $display("FAIL down_pre: got count=%0d step=%b expected 0/0", count, step); else n_pass++;
    tick();
    n_total++; if (count !== 3'd5) $display("FAIL down_wrap_count: got %0d expected 5", count); else n_pass++;
    n_total++; if (wrap !== 1'b1 || step !== 1'b1) $display("FAIL down_wrap_strobes: got wrap=%b step=%b expected 1/1", wrap, step); else n_pass++;
    tick();
    n_total++; if (wrap !== 1'b0 || step !== 1'b0) $display("FAIL down_strobe_width: got wrap=%b step=%b expected 0/0", wrap, step); else n_pass++;
    repeat (3) tick();
    n_total++; if (count !== 3'd4 || step !== 1'b1 || wrap !== 1'b0) $display("FAIL down_next: got count=%0d step=%b wrap=%b expected 4/1/0", count, step, wrap); else n_pass++;
  endtask

  task automatic test_load_edge();
    en = 1'b0; up_down = 1'b1;
    load = 1'b1; load_val = 3'd7; tick();
    n_total++; if (count !== 3'd5) $display("FAIL load_clamp: got %0d expected 5", count); else n_pass++;
    load = 1'b0; en = 1'b1;
    repeat (3) tick();
    load = 1'b1; load_val = 3'd2; tick();
    n_total++; if (count !== 3'd2 || step !== 1'b0 || wrap !== 1'b0) $display("FAIL load_over_step: got count=%0d step=%b wrap=%b expected 2/0/0", count, step, wrap); else n_pass++;
    load = 1'b0;
    repeat (3) tick();
    n_total++; if (count !== 3'd2 || step !== 1'b0) $display("FAIL load_prescale_restart: got count=%0d step=%b expected 2/0", count, step); else n_pass++;
    tick();
    n_total++; if (count !== 3'd3 || step !== 1'b1) $display("FAIL load_next_step: got count=%0d step=%b expected 3/1", count, step); else n_pass++;
  endtask

  task automatic test_en_gaps();
    logic [2:0] exp_c;
    logic       exp_s;
    load = 1'b1; load_val = 3'd0; tick();
    load = 1'b0; up_down = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      en = (i % 2 == 1);
      tick();
      exp_s = (i == 7 || i == 15);
      exp_c = (i >= 15) ? 3'd2 : ((i >= 7) ? 3'd1 : 3'd0);
      n_total++; if (step !== exp_s) $display("FAIL gap_step[%0d]: got %b expected %b", i, step, exp_s); else n_pass++;
      n_total++; if (count !== exp_c) $display("FAIL gap_count[%0d]: got %0d expected %0d", i, count, exp_c); else n_pass++;
    end
    en = 1'b1;
    repeat (2) tick();
    up_down = 1'b0;
    tick();
    n_total++; if (count !== 3'd2 || step !== 1'b0) $display("FAIL dir_flip_pre: got count=%0d step=%b expected 2/0", count, step); else n_pass++;
    tick();
    n_total++; if (count !== 3'd1 || step !== 1'b1) $display("FAIL dir_flip_step: got count=%0d step=%b expected 1/1", count, step); else n_pass++;
    en = 1'b0;
  endtask

  task automatic test_cascade();
    int hi_wraps, lo_wraps;
    hi_wraps = 0; lo_wraps = 0;
    c_en = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (lo_wrap === 1'b1) lo_wraps++;
      if (hi_wrap === 1'b1) hi_wraps++;
      if (i == 7) begin
        n_total++; if (lo_count !== 3'd1 || hi_count !== 3'd1) $display("FAIL cascade_carry: got %0d%0d expected 11", hi_count, lo_count); else n_pass++;
      end
    end
    c_en = 1'b0;
    tick();
    if (hi_wrap === 1'b1) hi_wraps++;
    n_total++; if (lo_count !== 3'd0 || hi_count !== 3'd0) $display("FAIL cascade_final: got %0d%0d expected 00", hi_count, lo_count); else n_pass++;
    n_total++; if (hi_wraps != 1) $display("FAIL cascade_hi_wraps: got %0d expected 1", hi_wraps); else n_pass++;
    n_total++; if (lo_wraps != 6) $display("FAIL cascade_lo_wraps: got %0d expected 6", lo_wraps); else n_pass++;
  endtask

  task automatic test_decade();
    logic [3:0] exp_c;
    logic       exp_w;
    m_load = 1'b1; m_load_val = 4'd15; tick();
    n_total++; if (m_count !== 4'd9) $display("FAIL dec_clamp: got %0d expected 9", m_count); else n_pass++;
    m_load_val = 4'd0; tick();
    m_load = 1'b0; m_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_c = 4'(i % 10);
      exp_w = (i % 10 == 0);
      n_total++; if (m_count !== exp_c) $display("FAIL dec_count[%0d]: got %0d expected %0d", i, m_count, exp_c); else n_pass++;
      n_total++; if (m_wrap !== exp_w || m_step !== 1'b1) $display("FAIL dec_strobes[%0d]: got wrap=%b step=%b expected %b/1", i, m_wrap, m_step, exp_w); else n_pass++;
    end
    m_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_down = 1'b1; load = 1'b0; load_val = 3'd0;
    c_en = 1'b0; m_en = 1'b0; m_load = 1'b0; m_load_val = 4'd0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_edge();
    test_en_gaps();
    test_cascade();
    test_decade();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
